// File: rtl/p_mul_core.sv
// p_mul_core: packed multiplier for the crypto ISE execute stage.
// Multiplies crs1 by crs2 as independent packed lanes of 32/16/8/4/2 bits. Each lane yields the
// low or high half of its 2w-bit product, as an integer or carry-less (GF(2)) multiply.
// An iterative engine consumes one multiplier bit per lane per cycle for 32 cycles.
//
// Ports:
//   clock   in   rising-edge clock
//   resetn  in   asynchronous reset, ACTIVE HIGH despite the name
//   valid   in   request, held with stable operands until ready
//   ready   out  one-cycle completion pulse; result valid in that cycle
//   mul_l   in   select low half (default when mul_h is 0)
//   mul_h   in   select high half (wins over mul_l)
//   clmul   in   1 = carry-less multiply, 0 = unsigned multiply
//   pw      in   [4:0] one-hot lane width (bit0=32 ... bit4=2); lowest set bit wins, 0 -> 32
//   crs1    in   [31:0] packed multiplicand
//   crs2    in   [31:0] packed multiplier
//   result  out  [31:0] packed result
module p_mul_core (
  input  logic        clock,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic        mul_l,
  input  logic        mul_h,
  input  logic        clmul,
  input  logic [4:0]  pw,
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
  output logic [31:0] result
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Low half is the default, so mul_l carries no information of its own.
  logic unused_mul_l;
  assign unused_mul_l = mul_l;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  wsel_q, wsel_d;
  logic        hi_q, hi_d, cl_q, cl_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  wsel_in;
  logic [63:0] acc_step;

  // One engine step: lane j's product occupies acc[2jw +: 2w]. Multiplier bit k of each lane
  // adds (or XORs) the lane multiplicand shifted by k. Steps with k >= w leave the lane alone.
  function automatic logic [63:0] mul_step(input logic [63:0] acc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] k,
                                           input logic [2:0] wsel, input logic cl);
    logic [63:0] nxt, m1, m2, al, addend, lane;
    logic [31:0] bs;
    int w;
    nxt = acc;
    for (int wi = 0; wi < 5; wi++) begin
      w = 32 >> wi;
      if (wsel == 3'(wi)) begin
        m1 = (64'd1 << w) - 64'd1;
        m2 = (64'd1 << (2 * w)) - 64'd1;  // wraps to all ones for w = 32
        for (int j = 0; j < 16; j++) begin
          if ((j * w) < 32 && int'(k) < w) begin
            bs = b >> (j * w + int'(k));
            if (bs[0]) begin
              al     = (64'(a) >> (j * w)) & m1;
              addend = (al << k) & m2;
              lane   = (acc >> (2 * j * w)) & m2;
              lane   = cl ? (lane ^ addend) : ((lane + addend) & m2);
              nxt    = (nxt & ~(m2 << (2 * j * w))) | (lane << (2 * j * w));
            end
          end
        end
      end
    end
    return nxt;
  endfunction

  // Pack the selected half of every lane product back into 32 bits.
  function automatic logic [31:0] pick(input logic [63:0] acc, input logic [2:0] wsel,
                                       input logic hi);
    logic [31:0] res;
    logic [63:0] m1, lane;
    int w, off;
    res = '0;
    for (int wi = 0; wi < 5; wi++) begin
      w = 32 >> wi;
      if (wsel == 3'(wi)) begin
        m1 = (64'd1 << w) - 64'd1;
        for (int j = 0; j < 16; j++) begin
          if ((j * w) < 32) begin
            off  = 2 * j * w + (hi ? w : 0);
            lane = (acc >> off) & m1;
            res  = res | 32'(lane << (j * w));
          end
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    if (pw[0])      wsel_in = 3'd0;
    else if (pw[1]) wsel_in = 3'd1;
    else if (pw[2]) wsel_in = 3'd2;
    else if (pw[3]) wsel_in = 3'd3;
    else if (pw[4]) wsel_in = 3'd4;
    else            wsel_in = 3'd0;
  end

  assign acc_step = mul_step(acc_q, a_q, b_q, cnt_q, wsel_q, cl_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    wsel_d   = wsel_q;
    hi_d     = hi_q;
    cl_d     = cl_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (valid) begin
          a_d     = crs1;
          b_d     = crs2;
          wsel_d  = wsel_in;
          hi_d    = mul_h;
          cl_d    = clmul;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!valid) begin
          state_d = StIdle;  // abort: request withdrawn
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = pick(acc_step, wsel_q, hi_q);
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wsel_q   <= '0;
      hi_q     <= 1'b0;
      cl_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wsel_q   <= wsel_d;
      hi_q     <= hi_d;
      cl_q     <= cl_d;
      result_q <= result_d;
    end
  end

  // Gated by valid so a withdrawn request can never see a completion.
  assign ready  = (state_q == StDone) && valid;
  assign result = result_q;

endmodule

// File: tb/tb_p_mul_core.sv
// Directed testbench for p_mul_core: reset state, latency, lane widths, halves, carry-less,
// abort, mid-operation reset and back-to-back requests.
module tb_p_mul_core;

  logic        clock = 1'b0;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic        mul_l;
  logic        mul_h;
  logic        clmul;
  logic [4:0]  pw;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  p_mul_core dut (
    .clock  (clock),
    .resetn (resetn),
    .valid  (valid),
    .ready  (ready),
    .mul_l  (mul_l),
    .mul_h  (mul_h),
    .clmul  (clmul),
    .pw     (pw),
    .crs1   (crs1),
    .crs2   (crs2),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called right after the acceptance edge: count negedges until ready, check latency and
  // result, then confirm the pulse is a single cycle.
  task automatic finish_op(input string tag, input logic [31:0] exp, input bit keep);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (ready === 1'b1) break;
    end
    check({tag, "_latency"}, 32'(n), 32'd33);
    check({tag, "_result"}, result, exp);
    @(posedge clock);
    #1;
    check({tag, "_pulse"}, 32'(ready), 32'd0);
    if (!keep) valid = 1'b0;
  endtask

  // Must be called #1 after a rising edge with the DUT idle.
  task automatic run_op(input string tag, input logic [4:0] p, input logic c, input logic l,
                        input logic h, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit keep);
    pw    = p;
    clmul = c;
    mul_l = l;
    mul_h = h;
    crs1  = a;
    crs2  = b;
    valid = 1'b1;
    @(posedge clock);
    finish_op(tag, exp, keep);
  endtask

  initial begin
    int cnt;
    resetn = 1'b1;
    valid  = 1'b0;
    mul_l  = 1'b0;
    mul_h  = 1'b0;
    clmul  = 1'b0;
    pw     = 5'b00001;
    crs1   = '0;
    crs2   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_result", result, 32'd0);
    resetn = 1'b0;
    @(posedge clock);
    #1;

    run_op("w32_lo",    5'b00001, 0, 1, 0, 32'h1,        32'h4,        32'h00000004, 0);
    run_op("w32_ff_lo", 5'b00001, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
    run_op("w32_ff_hi", 5'b00001, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op("w32_both",  5'b00001, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op("w16_lo",    5'b00010, 0, 1, 0, 32'h00030002, 32'h00050007, 32'h000F000E, 0);
    run_op("w16_nonoh", 5'b00110, 0, 1, 0, 32'h00030002, 32'h00050007, 32'h000F000E, 0);
    run_op("w8_hi",     5'b00100, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFEFEFEFE, 0);
    run_op("w4_lo",     5'b01000, 0, 1, 0, 32'h12345678, 32'h22222222, 32'h2468ACE0, 0);
    run_op("w2_hi",     5'b10000, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 0);
    run_op("w2_lo",     5'b10000, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 0);
    run_op("pw0_w32",   5'b00000, 0, 1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 0);
    run_op("cl32_lo",   5'b00001, 1, 1, 0, 32'h3,        32'h3,        32'h00000005, 0);
    run_op("cl32_hi",   5'b00001, 1, 0, 1, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op("cl32_ff",   5'b00001, 1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 0);
    run_op("cl8_lo",    5'b00100, 1, 1, 0, 32'h03030303, 32'h03030303, 32'h05050505, 0);

    // Abort: withdraw valid after 10 BUSY cycles; no ready may follow.
    pw = 5'b00001; clmul = 0; mul_l = 1; mul_h = 0; crs1 = 32'h7; crs2 = 32'h9;
    valid = 1'b1;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    valid = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (ready !== 1'b0) cnt++;
    end
    check("abort_no_ready", 32'(cnt), 32'd0);
    @(posedge clock);
    #1;
    run_op("after_abort", 5'b00001, 0, 1, 0, 32'h7, 32'h9, 32'h0000003F, 0);

    // Mid-operation reset clears outputs at once; held request restarts afterwards.
    pw = 5'b00010; clmul = 0; mul_l = 0; mul_h = 1; crs1 = 32'hFFFFFFFF; crs2 = 32'hFFFFFFFF;
    valid = 1'b1;
    @(posedge clock);
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b1;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    finish_op("rst_restart", 32'hFFFEFFFE, 0);

    // Back-to-back: valid stays high, operands change right after each ready cycle.
    run_op("b2b_0", 5'b00001, 0, 1, 0, 32'd1000,     32'd1000,     32'd1000000,  1);
    run_op("b2b_1", 5'b01000, 0, 0, 1, 32'hFFFFFFFF, 32'h22222222, 32'h11111111, 1);
    run_op("b2b_2", 5'b00100, 1, 1, 0, 32'h0F0F0F0F, 32'h02020202, 32'h1E1E1E1E, 1);
    run_op("b2b_3", 5'b00010, 0, 0, 1, 32'h80000002, 32'h00040003, 32'h00020000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
